// File: rtl/uart_baud_gen_frac_pkg.sv
// Shared constants and types for the UART baud generator and the uart_tx/uart_rx engines.
package uart_baud_gen_frac_pkg;

  localparam int          DEF_INT_BITS   = 16;
  localparam int          DEF_FRAC_BITS  = 4;
  localparam int          DEF_OVERSAMPLE = 16;
  localparam logic [15:0] DEF_RESET_DIV  = 16'd27;

  typedef struct packed {
    logic os_tick;
    logic mid_tick;
    logic bit_tick;
  } tick_t;

  function automatic int os_cnt_width(input int oversample);
    return $clog2(oversample);
  endfunction

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Control/tick bundle between the CSR side (master) and the baud generator (slave).
interface uart_baud_gen_frac_if #(
  parameter int INT_BITS  = uart_baud_gen_frac_pkg::DEF_INT_BITS,
  parameter int FRAC_BITS = uart_baud_gen_frac_pkg::DEF_FRAC_BITS
);

  logic                 enable;
  logic                 restart;
  logic [INT_BITS-1:0]  divisor_int;
  logic [FRAC_BITS-1:0] divisor_frac;
  logic                 divisor_load;
  logic                 os_tick;
  logic                 mid_tick;
  logic                 bit_tick;
  logic                 div_pending;

  modport master (
    output enable, restart, divisor_int, divisor_frac, divisor_load,
    input  os_tick, mid_tick, bit_tick, div_pending
  );

  modport slave (
    input  enable, restart, divisor_int, divisor_frac, divisor_load,
    output os_tick, mid_tick, bit_tick, div_pending
  );

endinterface

// File: rtl/uart_baud_gen_frac_accum.sv
// Fractional phase accumulator: the carry out of each advance stretches the next period by one clock.
module uart_baud_gen_frac_accum
  import uart_baud_gen_frac_pkg::*;
#(
  parameter int FRAC_BITS = DEF_FRAC_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_clear,
  input  logic                 i_advance,
  input  logic [FRAC_BITS-1:0] i_frac,
  output logic                 o_extra
);

  logic [FRAC_BITS-1:0] r_acc;
  logic                 r_extra;
  logic [FRAC_BITS:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, i_frac};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_extra <= 1'b0;
    end else if (i_clear) begin
      r_acc   <= '0;
      r_extra <= 1'b0;
    end else if (i_advance) begin
      r_acc   <= w_sum[FRAC_BITS-1:0];
      r_extra <= w_sum[FRAC_BITS];
    end
  end

  assign o_extra = r_extra;

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional baud generator: os_tick averages divisor_int + divisor_frac/2^FRAC_BITS clocks;
// mid_tick/bit_tick are decoded from the oversample counter for the RX sample point and bit edge.
module uart_baud_gen_frac
  import uart_baud_gen_frac_pkg::*;
#(
  parameter int                  INT_BITS   = DEF_INT_BITS,
  parameter int                  FRAC_BITS  = DEF_FRAC_BITS,
  parameter int                  OVERSAMPLE = DEF_OVERSAMPLE,
  parameter logic [INT_BITS-1:0] RESET_DIV  = DEF_RESET_DIV
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_baud_gen_frac_if.slave bus
);

  localparam int                  OSW     = os_cnt_width(OVERSAMPLE);
  localparam logic [OSW-1:0]      MID_IDX = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0]      BIT_IDX = OSW'(OVERSAMPLE - 1);
  localparam logic [INT_BITS-1:0] ONE     = INT_BITS'(1);

  logic [INT_BITS-1:0]  r_cnt;
  logic [INT_BITS-1:0]  r_div_int_q;
  logic [FRAC_BITS-1:0] r_div_frac_q;
  logic [INT_BITS-1:0]  r_shadow_int;
  logic [FRAC_BITS-1:0] r_shadow_frac;
  logic                 r_pending;
  logic [OSW-1:0]       r_os_cnt;
  tick_t                r_ticks;

  logic                 w_extra;
  logic                 w_wrap;
  logic                 w_apply;
  logic [INT_BITS-1:0]  w_div_eff;
  logic [INT_BITS-1:0]  w_term;

  // A programmed divisor of 0 runs like 1; the carried fraction adds one clock to this period.
  assign w_div_eff = (r_div_int_q == '0) ? ONE : r_div_int_q;
  assign w_term    = w_div_eff - ONE + INT_BITS'(w_extra);
  assign w_wrap    = bus.enable && !bus.restart && (r_cnt == w_term);
  assign w_apply   = r_pending && (bus.restart || !bus.enable || w_wrap);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_os_cnt <= '0;
      r_ticks  <= '0;
    end else if (bus.restart) begin
      r_cnt    <= '0;
      r_os_cnt <= '0;
      r_ticks  <= '0;
    end else if (bus.enable) begin
      r_ticks.os_tick  <= w_wrap;
      r_ticks.mid_tick <= w_wrap && (r_os_cnt == MID_IDX);
      r_ticks.bit_tick <= w_wrap && (r_os_cnt == BIT_IDX);
      if (w_wrap) begin
        r_cnt    <= '0;
        r_os_cnt <= r_os_cnt + OSW'(1);
      end else begin
        r_cnt    <= r_cnt + ONE;
      end
    end else begin
      r_ticks  <= '0;
    end
  end

  // The shadow only goes live at a period boundary, so a load seen on a wrap edge waits a full period.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_int_q   <= RESET_DIV;
      r_div_frac_q  <= '0;
      r_shadow_int  <= RESET_DIV;
      r_shadow_frac <= '0;
      r_pending     <= 1'b0;
    end else begin
      if (w_apply) begin
        r_div_int_q  <= r_shadow_int;
        r_div_frac_q <= r_shadow_frac;
      end
      if (bus.divisor_load) begin
        r_shadow_int  <= bus.divisor_int;
        r_shadow_frac <= bus.divisor_frac;
        r_pending     <= 1'b1;
      end else if (w_apply) begin
        r_pending     <= 1'b0;
      end
    end
  end

  uart_baud_gen_frac_accum #(
    .FRAC_BITS (FRAC_BITS)
  ) u_accum (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_clear   (bus.restart),
    .i_advance (w_wrap),
    .i_frac    (r_div_frac_q),
    .o_extra   (w_extra)
  );

  assign bus.os_tick     = r_ticks.os_tick;
  assign bus.mid_tick    = r_ticks.mid_tick;
  assign bus.bit_tick    = r_ticks.bit_tick;
  assign bus.div_pending = r_pending;

endmodule
